// File: rtl/sum_sqrt_seq.sv
// Purpose: sequential floor(sqrt(a)) using the shift-subtract method, one root bit per clock.
// Latency: done pulses OUT_W edges after the accepting edge; one new operation every OUT_W+1 cycles.
// Backpressure: start is only honoured while idle; start raised during busy is dropped.
module sum_sqrt_seq #(
    parameter int IN_W  = 9,
    parameter int OUT_W = (IN_W + 1) / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  a,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] res
);

    // x, y and m are twice the root width so neither the mask nor the
    // partial root can overflow during the first iteration.
    localparam int R_W   = 2 * OUT_W;
    localparam int CNT_W = $clog2(OUT_W + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WORK = 1'b1;

    logic [0:0]       state;
    logic [R_W-1:0]   x;
    logic [R_W-1:0]   y;
    logic [R_W-1:0]   m;
    logic [CNT_W-1:0] cnt;

    logic [R_W-1:0]   b;
    logic [R_W-1:0]   y_sh;
    logic             take;
    logic [R_W-1:0]   x_nxt;
    logic [R_W-1:0]   y_nxt;

    // One iteration of the digit-by-digit root: try to subtract (y|m) from the remainder.
    always_comb begin
        b     = y | m;
        y_sh  = y >> 1;
        take  = (x >= b);
        x_nxt = x;
        y_nxt = y_sh;
        if (take) begin
            x_nxt = x - b;
            y_nxt = y_sh | m;
        end
    end

    assign busy = (state == WORK);

    // Control and datapath registers; reset wins over everything, including start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            res   <= '0;
            x     <= '0;
            y     <= '0;
            m     <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x     <= R_W'(a);
                        y     <= '0;
                        m     <= R_W'(1) << (R_W - 2);
                        cnt   <= CNT_W'(OUT_W);
                        state <= WORK;
                    end
                end
                WORK: begin
                    x   <= x_nxt;
                    y   <= y_nxt;
                    m   <= m >> 2;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        res   <= y_nxt[OUT_W-1:0];
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_sqrt_seq.sv
module tb_sum_sqrt_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [8:0] a;
    logic       busy;
    logic       done;
    logic [4:0] res;

    int checks   = 0;
    int failures = 0;
    logic [4:0] prev_res;

    sum_sqrt_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled and inputs changed 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent floor-sqrt reference.
    function automatic logic [4:0] ref_sqrt(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return 5'(r);
    endfunction

    // One start pulse, then checks latency, res hold during busy, result and post-done hold.
    task automatic run_op(input logic [8:0] v, input logic [4:0] exp, input string name);
        int n;
        a     = v;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = 9'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
        end
        n = 0;
        while (n < 10) begin
            step();
            n++;
            if (done === 1'b1) break;
            checks++;
            if (res !== prev_res) begin
                failures++;
                $display("FAIL %s res_hold_busy: got %0d want %0d", name, res, prev_res);
            end
        end
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL %s latency: got %0d edges want 5", name, n);
        end
        checks++;
        if (res !== exp) begin
            failures++;
            $display("FAIL %s result: a=%0d got %0d want %0d", name, v, res, exp);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_with_done: got %b want 0", name, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || res !== exp) begin
            failures++;
            $display("FAIL %s after_done: done=%b res=%0d want done=0 res=%0d", name, done, res, exp);
        end
        prev_res = exp;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        a     = 9'd200;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || res !== 5'd0) begin
                failures++;
                $display("FAIL reset_state: busy=%b done=%b res=%0d want 0/0/0", busy, done, res);
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || res !== 5'd0) begin
                failures++;
                $display("FAIL reset_idle: busy=%b done=%b res=%0d want 0/0/0", busy, done, res);
            end
        end
        prev_res = 5'd0;
    endtask

    task automatic test_vectors();
        logic [8:0] vin [5] = '{9'd0, 9'd510, 9'd82, 9'd192, 9'd68};
        logic [4:0] vexp[5] = '{5'd0, 5'd22, 5'd9, 5'd13, 5'd8};
        for (int i = 0; i < 5; i++) begin
            run_op(vin[i], vexp[i], "vector");
            step();
            checks++;
            if (res !== vexp[i] || done !== 1'b0) begin
                failures++;
                $display("FAIL vector_hold: res=%0d done=%b want %0d/0", res, done, vexp[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [8:0] vin [6] = '{9'd1, 9'd3, 9'd4, 9'd255, 9'd256, 9'd511};
        logic [4:0] vexp[6] = '{5'd1, 5'd1, 5'd2, 5'd15, 5'd16, 5'd22};
        for (int i = 0; i < 6; i++) run_op(vin[i], vexp[i], "boundary");
        for (int v = 0; v < 512; v++) run_op(9'(v), ref_sqrt(v), "sweep");
    endtask

    task automatic test_start_busy();
        int n;
        int pulses;
        a     = 9'd100;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        a     = 9'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 3;
        pulses = 0;
        while (n < 12) begin
            if (done === 1'b1) break;
            step();
            n++;
        end
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL start_busy_latency: got %0d edges want 5", n);
        end
        checks++;
        if (res !== 5'd10) begin
            failures++;
            $display("FAIL start_busy_result: got %0d want 10", res);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_busy_extra: extra_done=%0d busy=%b want 0/0", pulses, busy);
        end
        prev_res = 5'd10;
    endtask

    task automatic test_back_to_back();
        int n;
        a     = 9'd49;
        start = 1'b1;
        step();
        a = 9'd121;
        n = 0;
        while (n < 10) begin
            step();
            n++;
            if (done === 1'b1) break;
        end
        checks++;
        if (n !== 5 || res !== 5'd7) begin
            failures++;
            $display("FAIL b2b_first: edges=%0d res=%0d want 5/7", n, res);
        end
        step();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || res !== 5'd7) begin
            failures++;
            $display("FAIL b2b_reaccept: busy=%b done=%b res=%0d want 1/0/7", busy, done, res);
        end
        start = 1'b0;
        n = 1;
        while (n < 12) begin
            step();
            n++;
            if (done === 1'b1) break;
        end
        checks++;
        if (n !== 6 || res !== 5'd11) begin
            failures++;
            $display("FAIL b2b_second: spacing=%0d res=%0d want 6/11", n, res);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: done=%b busy=%b want 0/0", done, busy);
        end
        prev_res = 5'd11;
    endtask

    task automatic test_reset_mid();
        int pulses;
        a     = 9'd400;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || res !== 5'd0) begin
            failures++;
            $display("FAIL reset_mid_state: busy=%b done=%b res=%0d want 0/0/0", busy, done, res);
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL reset_mid_abort: busy/done seen %0d times want 0", pulses);
        end
        prev_res = 5'd0;
        run_op(9'd400, 5'd20, "reset_mid_restart");
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        prev_res = '0;
        test_reset();
        test_vectors();
        test_boundaries();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
